// File: rtl/shared_sclk_arbiter_pkg.sv
// Shared definitions for the serial-clock pin arbiter: owner codes,
// FSM state encoding and default parameter values.
package shared_sclk_pkg;

   // Owner encoding as presented on oOWNER
   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_LCD  = 2'b01;
   localparam logic [1:0] OWN_ADC  = 2'b10;

   // Arbiter states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LCD_OWN = 2'd1,
      ADC_OWN = 2'd2,
      GUARD   = 2'd3
   } state_e;

   // Default parameter values
   localparam int DEF_GUARD_CYCLES = 4;
   localparam int DEF_MAX_HOLD     = 4096;
   localparam int DEF_HOLD_W       = 16;

endpackage

// File: rtl/shared_sclk_arbiter.sv
// Arbiter for the single GPIO serial-clock pin shared by the LCD 3-wire
// configuration controller and the touch-screen ADC SPI controller.
// One owner at a time, a guard gap of SCLK-low cycles between owners,
// and a yield request to the ADC when the LCD has waited too long.
module shared_sclk_arbiter
   import shared_sclk_pkg::*;
#(
   parameter int GUARD_CYCLES = DEF_GUARD_CYCLES,  // 1..255
   parameter int MAX_HOLD     = DEF_MAX_HOLD,      // 2..65535
   parameter int HOLD_W       = DEF_HOLD_W
) (
   input  logic       iCLK,
   input  logic       iRST,
   input  logic       iLCD_REQ,
   input  logic       iLCD_SCLK,
   output logic       oLCD_GNT,
   input  logic       iADC_REQ,
   input  logic       iADC_DCLK,
   output logic       oADC_GNT,
   output logic       oADC_YIELD,
   output logic       oSCLK,
   output logic [1:0] oOWNER,
   output logic [7:0] oYIELD_CNT
);

   localparam logic [7:0]        GUARD_LAST = 8'(GUARD_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(MAX_HOLD - 1);

   state_e            state_q,      state_d;
   logic [1:0]        last_owner_q, last_owner_d;
   logic [7:0]        guard_cnt_q,  guard_cnt_d;
   logic [HOLD_W-1:0] hold_cnt_q,   hold_cnt_d;
   logic              yield_q,      yield_d;
   logic [7:0]        yield_cnt_q,  yield_cnt_d;

   // Next-state and counter logic for the ownership FSM
   always_comb begin
      // NOTE: every _d starts from its _q so all paths assign it and no latch is inferred.
      state_d      = state_q;
      last_owner_d = last_owner_q;
      guard_cnt_d  = guard_cnt_q;
      hold_cnt_d   = hold_cnt_q;
      yield_d      = yield_q;
      yield_cnt_d  = yield_cnt_q;

      case (state_q)
         IDLE: begin
            // Fixed LCD priority when both ask from idle
            if (iLCD_REQ) begin
               state_d = LCD_OWN;
            end else if (iADC_REQ) begin
               state_d    = ADC_OWN;
               hold_cnt_d = '0;
            end
         end

         LCD_OWN: begin
            if (!iLCD_REQ) begin
               state_d      = GUARD;
               guard_cnt_d  = '0;
               last_owner_d = OWN_LCD;
            end
         end

         ADC_OWN: begin
            if (!iADC_REQ) begin
               state_d      = GUARD;
               guard_cnt_d  = '0;
               last_owner_d = OWN_ADC;
               hold_cnt_d   = '0;
               yield_d      = 1'b0;
            end else begin
               if (hold_cnt_q != HOLD_LAST) begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end
               // Raise yield once per ownership; it then sticks until ADC releases
               if (iLCD_REQ && (hold_cnt_q == HOLD_LAST) && !yield_q) begin
                  yield_d = 1'b1;
                  if (yield_cnt_q != 8'hFF) begin
                     yield_cnt_d = yield_cnt_q + 1'b1;
                  end
               end
            end
         end

         GUARD: begin
            if (guard_cnt_q == GUARD_LAST) begin
               // Round-robin: the requester that did not own last goes first
               if (last_owner_q == OWN_LCD) begin
                  if (iADC_REQ) begin
                     state_d    = ADC_OWN;
                     hold_cnt_d = '0;
                  end else if (iLCD_REQ) begin
                     state_d = LCD_OWN;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  if (iLCD_REQ) begin
                     state_d = LCD_OWN;
                  end else if (iADC_REQ) begin
                     state_d    = ADC_OWN;
                     hold_cnt_d = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end else begin
               guard_cnt_d = guard_cnt_q + 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State and counter registers with synchronous reset
   always_ff @(posedge iCLK) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (iRST) begin
         state_q      <= IDLE;
         last_owner_q <= OWN_ADC;
         guard_cnt_q  <= '0;
         hold_cnt_q   <= '0;
         yield_q      <= 1'b0;
         yield_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         guard_cnt_q  <= guard_cnt_d;
         hold_cnt_q   <= hold_cnt_d;
         yield_q      <= yield_d;
         yield_cnt_q  <= yield_cnt_d;
      end
   end

   // Output decode from registered state; SCLK is low whenever nobody owns the pin
   always_comb begin
      oLCD_GNT = 1'b0;
      oADC_GNT = 1'b0;
      oOWNER   = OWN_NONE;
      oSCLK    = 1'b0;
      case (state_q)
         LCD_OWN: begin
            oLCD_GNT = 1'b1;
            oOWNER   = OWN_LCD;
            oSCLK    = iLCD_SCLK;
         end
         ADC_OWN: begin
            oADC_GNT = 1'b1;
            oOWNER   = OWN_ADC;
            oSCLK    = iADC_DCLK;
         end
         default: ;
      endcase
   end

   assign oADC_YIELD = yield_q;
   assign oYIELD_CNT = yield_cnt_q;

endmodule
